// File: rtl/vault_pkg.sv
// Shared definitions for the vault code-submit interface (frontend and controller).
package vault_pkg;

   localparam int unsigned CODE_W_DEFAULT = 4;

   // Controller status encodings
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GRANT = 2'b01;
   localparam logic [1:0] ST_DENY  = 2'b10;
   localparam logic [1:0] ST_LOCK  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StSubmit,
      StWaitResp,
      StLocked
   } state_e;

endpackage

// File: rtl/vault_keypad_frontend.sv
// Keypad frontend: collects serial digits, submits the code, captures the controller status.
module vault_keypad_frontend
   import vault_pkg::*;
#(
   parameter int unsigned CODE_W      = CODE_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 1000,
   localparam int unsigned DIG_W      = $clog2(CODE_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic              key_bit,
   input  logic              key_enter,
   input  logic              key_clear,
   input  logic [1:0]        status_in,
   output logic [CODE_W-1:0] code_out,
   output logic              submit,
   output logic [DIG_W-1:0]  digits,
   output logic              busy,
   output logic [1:0]        result,
   output logic              result_valid,
   output logic              entry_err,
   output logic              locked
);

   // Counter only has to reach TIMEOUT_CYC-1
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   sh_q, sh_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [1:0]          res_q, res_d;
   logic                res_vld_q, res_vld_d;
   logic                err_q, err_d;

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sh_q      <= '0;
         dig_q     <= '0;
         cnt_q     <= '0;
         code_q    <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         dig_q     <= dig_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic: key priority clear > enter > valid, then inter-key timeout
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle, StCollect: begin
            if (key_clear) begin
               sh_d    = '0;
               dig_d   = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end else if (key_enter) begin
               cnt_d = '0;
               if (dig_q == DIG_W'(CODE_W)) begin
                  // code_out only ever changes here, so partial entries stay hidden
                  code_d  = sh_q;
                  state_d = StSubmit;
               end else begin
                  err_d   = 1'b1;
                  sh_d    = '0;
                  dig_d   = '0;
                  state_d = StIdle;
               end
            end else if (key_valid) begin
               if (dig_q != DIG_W'(CODE_W)) begin
                  sh_d  = {sh_q[CODE_W-2:0], key_bit};
                  dig_d = dig_q + 1'b1;
               end
               cnt_d   = '0;
               state_d = StCollect;
            end else if (state_q == StCollect) begin
               if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  err_d   = 1'b1;
                  sh_d    = '0;
                  dig_d   = '0;
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StSubmit: begin
            state_d = StWaitResp;
         end
         StWaitResp: begin
            // Fixed-latency capture; a repeated identical status is legal
            res_d     = status_in;
            res_vld_d = 1'b1;
            sh_d      = '0;
            dig_d     = '0;
            state_d   = (status_in == ST_LOCK) ? StLocked : StIdle;
         end
         StLocked: begin
            state_d = StLocked;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign code_out     = code_q;
   assign submit       = (state_q == StSubmit);
   assign busy         = (state_q == StSubmit) || (state_q == StWaitResp);
   assign digits       = dig_q;
   assign result       = res_q;
   assign result_valid = res_vld_q;
   assign entry_err    = err_q;
   assign locked       = (state_q == StLocked);

endmodule

// File: tb/tb_vault_keypad_frontend.sv
// Scoreboard bench for vault_keypad_frontend with a queue-based reference model.
module tb_vault_keypad_frontend;
   import vault_pkg::*;

   localparam int unsigned W = 4;
   localparam int unsigned T = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           key_valid, key_bit, key_enter, key_clear;
   logic [1:0]     status_in;
   logic [W-1:0]   code_out;
   logic           submit;
   logic [$clog2(W+1)-1:0] digits;
   logic           busy;
   logic [1:0]     result;
   logic           result_valid, entry_err, locked;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   vault_keypad_frontend #(.CODE_W(W), .TIMEOUT_CYC(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_bit      (key_bit),
      .key_enter    (key_enter),
      .key_clear    (key_clear),
      .status_in    (status_in),
      .code_out     (code_out),
      .submit       (submit),
      .digits       (digits),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .entry_err    (entry_err),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   // Edge index: cycle after edge k is observed at negedge with edge_cnt == k
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef enum int {EvCode, EvSubmit, EvResult, EvErr} ev_kind_e;
   typedef struct {
      ev_kind_e     kind;
      int           at;
      logic [W-1:0] val;
   } ev_t;

   ev_t exp_q[$];

   // Reference model state
   bit         m_bits[$];
   bit         m_collect;
   int         m_last;
   bit         m_locked;
   int         m_ent = -100;
   logic [1:0] m_status;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Monitor: pop expected events due this cycle and compare against DUT outputs
   logic [W-1:0] hold_code = '0;
   logic         e_sub, e_res, e_err;
   logic [1:0]   e_rv;
   ev_t          ev;
   always @(negedge clk) begin
      if (rst) begin
         hold_code = '0;
      end else begin
         e_sub = 1'b0; e_res = 1'b0; e_err = 1'b0; e_rv = 2'b00;
         while (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
            ev = exp_q.pop_front();
            if (ev.at < edge_cnt) begin
               checks++;
               errors++;
               $display("FAIL overdue event kind %0d: due edge %0d, now %0d", ev.kind, ev.at, edge_cnt);
            end else begin
               case (ev.kind)
                  EvCode:   hold_code = ev.val;
                  EvSubmit: e_sub = 1'b1;
                  EvResult: begin e_res = 1'b1; e_rv = ev.val[1:0]; end
                  EvErr:    e_err = 1'b1;
                  default:  ;
               endcase
            end
         end
         check("submit", submit, e_sub);
         check("result_valid", result_valid, e_res);
         if (e_res) check("result", result, e_rv);
         check("entry_err", entry_err, e_err);
         check("code_out", code_out, hold_code);
      end
   end

   task automatic model_clear();
      m_bits.delete();
      m_collect = 1'b0;
   endtask

   // Behaviour at sampling edge s for the given strobes
   task automatic model(input int s, input bit v, input bit b, input bit e, input bit c,
                        input logic [1:0] st);
      logic [W-1:0] code;
      if (s == m_ent + 2) begin
         exp_q.push_back('{kind: EvResult, at: s, val: W'(m_status)});
         model_clear();
         if (m_status == ST_LOCK) m_locked = 1'b1;
      end else if (m_locked || s == m_ent + 1) begin
         // keys ignored
      end else if (c) begin
         model_clear();
      end else if (e) begin
         if (m_bits.size() < W) begin
            exp_q.push_back('{kind: EvErr, at: s, val: '0});
            model_clear();
         end else begin
            code = '0;
            for (int i = 0; i < W; i++) code = {code[W-2:0], m_bits[i]};
            exp_q.push_back('{kind: EvCode, at: s, val: code});
            exp_q.push_back('{kind: EvSubmit, at: s, val: code});
            m_ent     = s;
            m_status  = st;
            m_collect = 1'b0;
         end
      end else if (v) begin
         m_collect = 1'b1;
         m_last    = s;
         if (m_bits.size() < W) m_bits.push_back(b);
      end else if (m_collect && (s - m_last) == T) begin
         exp_q.push_back('{kind: EvErr, at: s, val: '0});
         model_clear();
      end
   endtask

   // One clock of stimulus, then per-cycle state checks
   task automatic step(input bit v, input bit b, input bit e, input bit c, input logic [1:0] st);
      int  s;
      bit  bsy;
      s = edge_cnt + 1;
      key_valid = v;
      key_bit   = v ? b : 1'($urandom);
      key_enter = e;
      key_clear = c;
      status_in = (s == m_ent + 2) ? m_status : 2'($urandom);
      model(s, v, b, e, c, st);
      @(posedge clk);
      #1;
      key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
      bsy = (s == m_ent) || (s == m_ent + 1);
      check("busy", busy, bsy);
      check("locked", locked, m_locked);
      check("digits", digits, bsy ? W : m_bits.size());
   endtask

   task automatic key(input bit b);
      step(1'b1, b, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic enter(input logic [1:0] st);
      step(1'b0, 1'b0, 1'b1, 1'b0, st);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " submit"}, submit, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " digits"}, digits, 0);
      check({tag, " result"}, result, 0);
      check({tag, " result_valid"}, result_valid, 0);
      check({tag, " entry_err"}, entry_err, 0);
      check({tag, " locked"}, locked, 0);
      check({tag, " code_out"}, code_out, 0);
   endtask

   // Asynchronous reset asserted mid-cycle; model returns to idle
   task automatic do_reset();
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("reset");
      exp_q.delete();
      model_clear();
      m_locked = 1'b0;
      m_ent    = -100;
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic full_code(input logic [W-1:0] c, input logic [1:0] st);
      logic [W-1:0] cc;
      cc = c;
      for (int i = W - 1; i >= 0; i--) key(cc[i]);
      enter(st);
      idle(3);
   endtask

   initial begin
      int op;
      rst = 1'b1;
      key_valid = 1'b0; key_bit = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
      status_in = 2'b00;
      m_collect = 1'b0; m_locked = 1'b0; m_last = 0; m_status = 2'b00;
      #3;
      check_all_zero("init");
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic submit, granted
      full_code(4'b1011, ST_GRANT);
      // Short entry
      key(1); key(0); key(1); enter(ST_GRANT); idle(2);
      // Overlong entry keeps the first four digits
      key(1); key(1); key(0); key(0); key(1); key(0); enter(ST_DENY); idle(3);
      // Repeated identical status and a 00 response
      full_code(4'b0110, ST_DENY);
      full_code(4'b0001, ST_IDLE);
      // Inter-key timeout, and a key just before expiry keeps the entry alive
      key(1); idle(T + 2);
      key(0); idle(T - 1); key(1); idle(T + 1);
      // Clear beats valid, enter beats valid, clear beats enter
      key(1); key(0); step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
      key(1); step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      key(1); key(1); key(1); key(1); step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         op = $urandom_range(0, 99);
         if (op < 50) key(1'($urandom));
         else if (op < 62) enter(($urandom_range(0, 7) == 0) ? ST_LOCK : 2'($urandom_range(0, 2)));
         else if (op < 67) step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
         else if (op < 70) idle(T + $urandom_range(0, 2) - 1);
         else if (op < 72) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                2'($urandom_range(0, 2)));
         else idle(1);
         if (m_locked && $urandom_range(0, 9) == 0) do_reset();
      end
      do_reset();

      // Lockout sequence
      for (int i = 0; i < 3; i++) full_code(4'($urandom), ST_DENY);
      full_code(4'b0101, ST_LOCK);
      full_code(4'b1111, ST_GRANT);
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      idle(T + 2);
      do_reset();

      // Reset during SUBMIT, then normal operation
      key(1); key(1); key(1); key(0); enter(ST_GRANT);
      check("submit before reset", submit, 1);
      do_reset();
      full_code(4'b1001, ST_GRANT);
      idle(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending events: got %0d left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/vault_keypad_frontend.md
Name: vault_keypad_frontend

Overview:
- Initiator side of the vault code-submit interface.
- Assembles a code from serial single-bit key presses, presents it on code_out with a one-cycle submit pulse, then captures the status word the vault controller returns.
- Sits between the keypad scanner and the vault controller.
- Reports per-attempt results and enters a sticky local lockout when the controller reports lockout.

Parameters:
CODE_W, 4, code width in bits; must match the controller's code width
TIMEOUT_CYC, 1000, idle cycles allowed between key presses in COLLECT before the partial entry is discarded

Ports:
clk  in  1  clock
rst  in  1  reset
key_valid  in  1  one-cycle strobe: key_bit is a new digit
key_bit  in  1  digit value (0/1)
key_enter  in  1  one-cycle strobe: submit the entry
key_clear  in  1  one-cycle strobe: discard the entry
status_in  in  2  controller status: 00 idle, 01 granted, 10 denied, 11 locked
code_out  out  CODE_W  code presented to the controller
submit  out  1  one-cycle submit pulse to the controller
digits  out  $clog2(CODE_W+1)  digits entered so far
busy  out  1  high in SUBMIT and WAIT_RESP
result  out  2  last captured status_in
result_valid  out  1  one-cycle pulse when result updates
entry_err  out  1  one-cycle pulse: enter with short entry, or inter-key timeout
locked  out  1  sticky lockout indicator

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All outputs 0, shift register 0, timeout counter 0, state IDLE. Reset in any state, including mid-SUBMIT, aborts with no further submit.
- States: IDLE, COLLECT, SUBMIT, WAIT_RESP, LOCKED.
- Key priority within one cycle: key_clear > key_enter > key_valid. Lower-priority strobes in the same cycle are dropped.
- IDLE/COLLECT, key_valid:
  - Shift MSB-first: sh <= {sh[CODE_W-2:0], key_bit}.
  - digits increments, saturating at CODE_W; extra digits are dropped and sh is unchanged.
  - Timeout counter clears; state goes to COLLECT.
- key_clear: sh=0, digits=0, timeout counter=0, go to IDLE. No error pulse.
- key_enter with digits<CODE_W: entry_err pulses, entry is cleared, go to IDLE, no submit.
- key_enter with digits==CODE_W: go to SUBMIT.
- COLLECT timeout: counter increments each cycle without a key. When it reaches TIMEOUT_CYC-1, entry_err pulses, entry clears, go to IDLE.
- Entry timing (enter sampled at edge N):
  - SUBMIT occupies cycle N+1. code_out<=sh is registered at edge N and held stable until the next SUBMIT, so partial entries never appear on code_out. submit=1 for exactly that cycle.
  - WAIT_RESP occupies cycle N+2. status_in is sampled at the end of N+2, with fixed latency and no change detection, because a repeated identical status is legal.
  - result and result_valid=1 appear in cycle N+3. sh and digits clear.
  - If the captured status is 11, go to LOCKED; otherwise go to IDLE.
- SUBMIT and WAIT_RESP: all key strobes are ignored and busy=1.
- LOCKED: locked=1, all keys ignored, submit is never asserted. The only exit is rst.
- Captured 00 (controller not updated) is reported as-is; no retry.

Decomposition:
- Shared package vault_pkg holds the status encodings (ST_IDLE=2'b00, ST_GRANT=2'b01, ST_DENY=2'b10, ST_LOCK=2'b11), the state enum, and the default CODE_W. The controller is updated to import it.
- No sub-module. The timeout counter and shift register stay inline.

Test Plan:
- Keys 1,0,1,1 then enter at edge N; status_in=01 in N+2 -> code_out=4'b1011 from N+1, submit high only in N+1, result=01 with result_valid in N+3, digits=0.
- Keys 1,0,1 then enter -> entry_err pulse, no submit, digits=0, state IDLE.
- 6 digits 1,1,0,0,1,0 then enter -> only the first 4 are kept, code_out=4'b1100, one submit.
- Three wrong codes answered with 10, then a fourth answered with 11 -> three result=10 pulses, then result=11, locked=1; further keys and enter produce no submit.
- One digit then TIMEOUT_CYC idle cycles -> entry_err pulse, digits=0. key_valid and key_clear in the same cycle -> clear wins, digits=0.
- rst asserted during SUBMIT -> submit drops immediately, all outputs 0; a subsequent full entry works normally.
